tc_encode: RTL
==============

TC_ENCODE -- requirements
Module: tc_encode

Interface
REQ-001 Parameters: none; all widths and constants are fixed by the shared package.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request a conversion; sampled only in IDLE.
REQ-006 tx10  in  18  signed temperature in 1/160-degree units (tenths of a degree x16).
REQ-007 c_f  in  1  scale select; 1 = Fahrenheit, 0 = Celsius.
REQ-008 tc  out  13  signed sensor code in 1/16 degC units; registered.
REQ-009 sat  out  1  high when the last result was clamped; registered with tc.
REQ-010 busy  out  1  high whenever the state is not IDLE.
REQ-011 done  out  1  one-cycle pulse when tc and sat update.

Function
REQ-012 The block SHALL implement the inverse of the team's tc-to-tx10 conversion:
- Celsius: tc = round(tx10/10).
- Fahrenheit: tc = round((tx10-5120)/18).
REQ-013 Rounding SHALL be to nearest, with ties away from zero.
REQ-014 Arithmetic SHALL be sign-magnitude:
- offset subtraction at 19-bit signed width;
- magnitude 18-bit unsigned, plus divisor/2 (5 or 9) before dividing;
- quotient 18-bit unsigned, then re-signed.
REQ-015 Results above 4095 SHALL clamp to 4095, and results below -4096 SHALL clamp to -4096; sat=1 when clamped, else 0.
REQ-016 The FSM SHALL have states IDLE, PREP, DIV, FIX and DONE.
- IDLE -> PREP when start=1; tx10 and c_f are captured on that edge.
- PREP (1 cycle): subtract the offset, take the magnitude and sign, add the rounding term.
- DIV (18 cycles): restoring division, one quotient bit per cycle, MSB first.
- FIX (1 cycle): apply the sign and saturate; tc and sat are loaded at the end of FIX.
- DONE (1 cycle): done=1, then -> IDLE.
REQ-017 Latency: if start is sampled at edge N, done SHALL be high in the cycle after edge N+20, with tc valid in that same cycle.
REQ-018 start SHALL be ignored while busy=1; an ignored start causes no queued conversion.
REQ-019 start held high continuously SHALL begin a new conversion on the edge leaving DONE->IDLE +1, i.e. back-to-back spacing of 22 cycles.
REQ-020 tc and sat SHALL hold their value between done pulses; changes on tx10 and c_f during a conversion SHALL have no effect.
REQ-021 busy SHALL be 1 in PREP, DIV, FIX and DONE.

Reset
REQ-022 When rst=1 at an edge, the block SHALL enter IDLE with tc=0, sat=0, busy=0, done=0, and clear the divider registers.
REQ-023 rst SHALL take priority over start on the same edge.
REQ-024 rst during any state SHALL abort the conversion with no done pulse.

Structure
REQ-025 Package temp_pkg SHALL hold:
- TX10_W=18, TC_W=13;
- F_OFFSET=5120;
- DIV_C=10, DIV_F=18;
- TC_MAX=4095, TC_MIN=-4096;
- the FSM state enum typedef.
REQ-026 The 18-bit-by-5-bit restoring divider SHALL be a sub-module udiv_seq with ports load, dividend, divisor, quotient, and an iteration counter; tc_encode owns the FSM, sign and saturation.

Verification
REQ-027 The bench SHALL cover the following scenarios:
- C exact and rounding: c_f=0, tx10=250 -> tc=25; tx10=254 -> 25; tx10=255 -> 26; tx10=-255 -> -26; sat=0 in all cases.
- F conversion: c_f=1, tx10=12320 -> tc=400; tx10=-6400 -> tc=-640; tx10=5120 -> tc=0.
- Saturation: c_f=0, tx10=131071 -> tc=4095, sat=1; tx10=-131072 -> tc=-4096, sat=1.
- Latency/handshake: start pulsed at edge N -> done high only in the cycle after N+20, busy high from N+1 to N+21; a second start at N+5 is ignored, giving exactly one done.
- Reset mid-operation: rst asserted 10 cycles after start -> no done pulse, tc=0, busy=0; the next start converts normally.
- Back-to-back: start held high with tx10=160 (C) -> tc=16 and done pulses every 22 cycles.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared widths, constants and FSM state type for the temperature code encoder.
package temp_pkg;

    localparam int TX10_W   = 18;
    localparam int TC_W     = 13;
    localparam int DIFF_W   = TX10_W + 1;
    localparam int DIVR_W   = 5;
    localparam int CNT_W    = 5;

    localparam int F_OFFSET = 5120;
    localparam int DIV_C    = 10;
    localparam int DIV_F    = 18;
    localparam int TC_MAX   = 4095;
    localparam int TC_MIN   = -4096;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/tc_encode_if.sv
// Request/result bundle between a requester and the tx10-to-tc encoder.
interface tc_encode_if;
    import temp_pkg::*;

    logic                     start;
    logic signed [TX10_W-1:0] tx10;
    logic                     c_f;
    logic signed [TC_W-1:0]   tc;
    logic                     sat;
    logic                     busy;
    logic                     done;

    modport master (
        output start, tx10, c_f,
        input  tc, sat, busy, done
    );

    modport slave (
        input  start, tx10, c_f,
        output tc, sat, busy, done
    );

endinterface

// File: rtl/udiv_seq.sv
// Sequential restoring divider: 18-bit unsigned dividend by 5-bit divisor,
// one quotient bit per cycle, MSB first; count reaches 0 when finished.
module udiv_seq
    import temp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TX10_W-1:0] dividend,
    input  logic [DIVR_W-1:0] divisor,
    output logic [TX10_W-1:0] quotient,
    output logic [CNT_W-1:0]  count
);

    logic [DIVR_W-1:0] rem;
    logic [DIVR_W-1:0] divisor_q;
    logic [DIVR_W:0]   partial;
    logic [DIVR_W-1:0] trial;

    // NOTE: combinational signals get a full assignment on every path so no latch is inferred.
    always_comb begin
        partial = {rem, quotient[TX10_W-1]};
        trial   = partial[DIVR_W-1:0] - divisor_q;
    end

    // The quotient register doubles as the dividend shift register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            divisor_q <= '0;
            quotient  <= '0;
            count     <= '0;
        end else if (load) begin
            rem       <= '0;
            divisor_q <= divisor;
            quotient  <= dividend;
            count     <= CNT_W'(TX10_W);
        end else if (count != '0) begin
            if (partial >= {1'b0, divisor_q}) begin
                rem      <= trial;
                quotient <= {quotient[TX10_W-2:0], 1'b1};
            end else begin
                rem      <= partial[DIVR_W-1:0];
                quotient <= {quotient[TX10_W-2:0], 1'b0};
            end
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/tc_encode.sv
// Converts a tenths-x16 temperature (C or F) to a saturated 1/16 degC sensor code
// using sign-magnitude round-half-away-from-zero division.
module tc_encode
    import temp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    tc_encode_if.slave  bus
);

    state_t                   state;
    logic signed [TX10_W-1:0] tx10_q;
    logic                     c_f_q;
    logic                     neg;

    logic signed [DIFF_W-1:0] diff;
    logic [TX10_W-1:0]        mag;
    logic [TX10_W-1:0]        dividend;
    logic [DIVR_W-1:0]        divisor;
    logic [TX10_W-1:0]        quotient;
    logic [CNT_W-1:0]         count;
    logic                     load;

    always_comb begin
        diff = {tx10_q[TX10_W-1], tx10_q};
        if (c_f_q) begin
            diff = diff - DIFF_W'(F_OFFSET);
        end
        mag      = diff[DIFF_W-1] ? TX10_W'(-diff) : diff[TX10_W-1:0];
        divisor  = c_f_q ? DIVR_W'(DIV_F) : DIVR_W'(DIV_C);
        // Adding half the divisor to the magnitude gives ties-away-from-zero.
        dividend = mag + TX10_W'(divisor >> 1);
        load     = (state == PREP);
    end

    udiv_seq u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx10_q   <= '0;
            c_f_q    <= 1'b0;
            neg      <= 1'b0;
            bus.tc   <= '0;
            bus.sat  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx10_q   <= bus.tx10;
                        c_f_q    <= bus.c_f;
                        bus.busy <= 1'b1;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    neg   <= diff[DIFF_W-1];
                    state <= DIV;
                end
                DIV: begin
                    // The divider takes its final step on this edge.
                    if (count == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (neg) begin
                        if (quotient > TX10_W'(-TC_MIN)) begin
                            bus.tc  <= TC_W'(TC_MIN);
                            bus.sat <= 1'b1;
                        end else begin
                            bus.tc  <= -$signed(quotient[TC_W-1:0]);
                            bus.sat <= 1'b0;
                        end
                    end else begin
                        if (quotient > TX10_W'(TC_MAX)) begin
                            bus.tc  <= TC_W'(TC_MAX);
                            bus.sat <= 1'b1;
                        end else begin
                            bus.tc  <= $signed(quotient[TC_W-1:0]);
                            bus.sat <= 1'b0;
                        end
                    end
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
